// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns and index sizing.
// Latency: n/a (package). Backpressure: n/a.
// Contents: SEG_BLANK, SEG_TABLE (nibble -> {a..g}, active low), idx_width().
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index = nibble value; bit order {a,b,c,d,e,f,g}; 0 = segment lit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Width of a digit index register; never less than one bit so the
    // single-digit build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment pattern, with a forced-dark input.
// Latency: combinational. Backpressure: none.
// Ports: nibble_i (hex digit), blank_i (1 = all segments off), seg_o ({a..g}, active low).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            seg_o = SEG_TABLE[nibble_i];
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode display driver with tear-free frame updates.
// Latency: outputs registered, one cycle behind the scan counter; load lands in active at next frame start.
// Backpressure: none; load is a single-cycle strobe, the latest one before a frame wins.
// Ports: clk/reset_n; value/dp_in/digit_en captured by load; blank_lz live; anode/seg/dp_n/frame_start to pins.
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 8,
    parameter int REFRESH_DIV      = 50000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int                    IDX_W     = idx_width(NUM_DIGITS);
    localparam int                    CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, act_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
    logic [NUM_DIGITS-1:0]   pend_en_q, act_en_q;
    logic                    pend_dirty_q;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              seg_q, seg_dec;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_start_q;

    logic                    frame_tick;
    logic                    slot_dead;
    logic [NUM_DIGITS:0]     zero_above;
    logic [NUM_DIGITS-1:0]   dark;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic                    dark_sel;
    logic                    blank;

    // The counter sits at slot 0 of digit 0 for exactly one cycle per frame;
    // that is where the frame boundary (and the pending->active copy) happens.
    assign frame_tick = (cnt_q == '0) && (idx_q == '0);
    assign slot_dead  = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // zero_above[k]: digits k..N-1 are all zero or disabled. A digit is
    // leading-zero blanked only if it is zero and everything above it is.
    always_comb begin
        zero_above             = '0;
        dark                   = '0;
        zero_above[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above[k] = zero_above[k+1] &
                            ((act_val_q[4*k +: 4] == 4'h0) | ~act_en_q[k]);
            dark[k]       = ~act_en_q[k] |
                            (blank_lz & (k != 0) & (act_val_q[4*k +: 4] == 4'h0) &
                             zero_above[k+1]);
        end
    end

    always_comb begin
        nib_sel  = '0;
        dp_sel   = 1'b0;
        dark_sel = 1'b1;
        onehot   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_sel   = act_val_q[4*k +: 4];
                dp_sel    = act_dp_q[k];
                dark_sel  = dark[k];
                onehot[k] = ~slot_dead;
            end
        end
    end

    // Dead slot blanks segments and anodes; a dark digit keeps its anode.
    assign blank   = dark_sel | slot_dead;
    assign dp_n_d  = blank | ~dp_sel;
    assign anode_d = ANODE_ACTIVE_LOW ? ~onehot : onehot;

    seg7_decode u_decode (
        .nibble_i (nib_sel),
        .blank_i  (blank),
        .seg_o    (seg_dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            pend_dirty_q  <= 1'b0;
            act_val_q     <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
            anode_q       <= ANODE_OFF;
            seg_q         <= SEG_BLANK;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            anode_q       <= anode_d;
            seg_q         <= seg_dec;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_tick;
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
                pend_en_q  <= digit_en;
            end
            // A load on the boundary edge stays pending for the next frame.
            pend_dirty_q <= load | (pend_dirty_q & ~frame_tick);
            if (frame_tick && pend_dirty_q) begin
                act_val_q <= pend_val_q;
                act_dp_q  <= pend_dp_q;
                act_en_q  <= pend_en_q;
            end
        end
    end

    assign anode       = anode_q;
    assign seg         = seg_q;
    assign dp_n        = dp_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [3:0]  anode_l, anode_h;
    logic [6:0]  seg_l, seg_h;
    logic        dp_n_l, dp_n_h;
    logic        fs_l, fs_h;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ANODE_ACTIVE_LOW(1'b1)) u_al (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load), .dp_in(dp_in),
        .digit_en(digit_en), .blank_lz(blank_lz), .anode(anode_l), .seg(seg_l),
        .dp_n(dp_n_l), .frame_start(fs_l)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ANODE_ACTIVE_LOW(1'b0)) u_ah (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load), .dp_in(dp_in),
        .digit_en(digit_en), .blank_lz(blank_lz), .anode(anode_h), .seg(seg_h),
        .dp_n(dp_n_h), .frame_start(fs_h)
    );

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        blz;
        logic [27:0] eseg;   // {d3,d2,d1,d0}
        logic [3:0]  edpn;
    } vec_t;

    vec_t vecs[7];

    localparam logic [6:0] BLK = 7'b1111111;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
        value    = v;
        dp_in    = dp;
        digit_en = en;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (fs_l === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL %s: frame_start timeout got 0 want 1", name);
        end
    endtask

    // Checks one 16-cycle frame starting at the frame_start cycle. Loads of
    // value with all digits enabled may be injected at chosen cycles.
    task automatic check_frame(input string tag, input logic [27:0] es, input logic [3:0] ed,
                               input bit first_tick, input int l1c, input logic [15:0] l1v,
                               input int l2c, input logic [15:0] l2v);
        logic [3:0] oh;
        logic [6:0] es7;
        logic       ed1;
        int         d;
        int         s;
        for (int c = 0; c < 16; c++) begin
            if (c > 0 || first_tick) tick();
            load = 1'b0;
            d = c / 4;
            s = c % 4;
            if (s == 0) begin
                oh  = 4'b0000;
                es7 = BLK;
                ed1 = 1'b1;
            end else begin
                oh  = 4'b0001 << d;
                es7 = es[7*d +: 7];
                ed1 = ed[d];
            end
            check($sformatf("%s c%0d al", tag, c), {anode_l, seg_l, dp_n_l, fs_l},
                  {~oh, es7, ed1, (c == 0)});
            check($sformatf("%s c%0d ah", tag, c), {anode_h, seg_h, dp_n_h, fs_h},
                  {oh, es7, ed1, (c == 0)});
            if (c == l1c || c == l2c) begin
                value    = (c == l1c) ? l1v : l2v;
                dp_in    = 4'b0000;
                digit_en = 4'hF;
                load     = 1'b1;
            end
        end
    endtask

    initial begin
        vecs[0] = '{16'h12AF, 4'b0100, 4'hF, 1'b0,
                    {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b1011};
        vecs[1] = '{16'h0070, 4'b0000, 4'hF, 1'b1,
                    {BLK, BLK, 7'b0001111, 7'b0000001}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 4'hF, 1'b1,
                    {BLK, BLK, BLK, 7'b0000001}, 4'b1111};
        vecs[3] = '{16'h8888, 4'b1111, 4'b1010, 1'b0,
                    {7'b0000000, BLK, 7'b0000000, BLK}, 4'b0101};
        vecs[4] = '{16'h9035, 4'b0001, 4'b0111, 1'b1,
                    {BLK, BLK, 7'b0000110, 7'b0100100}, 4'b1110};
        vecs[5] = '{16'hBCDE, 4'b1000, 4'hF, 1'b1,
                    {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}, 4'b0111};
        vecs[6] = '{16'h1004, 4'b0000, 4'hF, 1'b1,
                    {7'b1001111, 7'b0000001, 7'b0000001, 7'b1001100}, 4'b1111};

        reset_n  = 1'b0;
        value    = '0;
        load     = 1'b0;
        dp_in    = '0;
        digit_en = '0;
        blank_lz = 1'b0;

        // Reset state, then the first frame after release (all dark, anodes scanned).
        repeat (3) tick();
        check("reset al", {anode_l, seg_l, dp_n_l, fs_l}, {4'b1111, BLK, 1'b1, 1'b0});
        check("reset ah", {anode_h, seg_h, dp_n_h, fs_h}, {4'b0000, BLK, 1'b1, 1'b0});
        reset_n = 1'b1;
        tick();
        check_frame("post_reset", {BLK, BLK, BLK, BLK}, 4'hF, 1'b0, -1, '0, -1, '0);

        foreach (vecs[i]) begin
            blank_lz = vecs[i].blz;
            do_load(vecs[i].val, vecs[i].dp, vecs[i].en);
            wait_frame($sformatf("vec%0d sync", i));
            check_frame($sformatf("vec%0d", i), vecs[i].eseg, vecs[i].edpn, 1'b0, -1, '0, -1, '0);
        end

        // Tear check: two loads mid-frame; only the last shows, and only next frame.
        blank_lz = 1'b0;
        do_load(16'h5555, 4'b0000, 4'hF);
        wait_frame("tear sync");
        check_frame("tear_cur", {4{7'b0100100}}, 4'hF, 1'b0, 5, 16'h1111, 10, 16'h2222);
        check_frame("tear_next", {4{7'b0010010}}, 4'hF, 1'b1, -1, '0, -1, '0);

        // Load sampled on the frame boundary edge: old value holds for that frame.
        check_frame("coin_pre", {4{7'b0010010}}, 4'hF, 1'b1, 15, 16'h3333, -1, '0);
        check_frame("coin_hold", {4{7'b0010010}}, 4'hF, 1'b1, -1, '0, -1, '0);
        check_frame("coin_new", {4{7'b0000110}}, 4'hF, 1'b1, -1, '0, -1, '0);

        // Reset mid-scan on digit 2 with a load pending.
        for (int c = 0; c <= 9; c++) begin
            tick();
            load = (c == 5);
            if (c == 5) value = 16'h7777;
        end
        load = 1'b0;
        check("mid digit2 al", {anode_l, seg_l, dp_n_l, fs_l}, {4'b1011, 7'b0000110, 1'b1, 1'b0});
        reset_n = 1'b0;
        #1;
        check("mid reset al", {anode_l, seg_l, dp_n_l, fs_l}, {4'b1111, BLK, 1'b1, 1'b0});
        check("mid reset ah", {anode_h, seg_h, dp_n_h, fs_h}, {4'b0000, BLK, 1'b1, 1'b0});
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check_frame("rst_f1", {BLK, BLK, BLK, BLK}, 4'hF, 1'b0, -1, '0, -1, '0);
        check_frame("rst_f2", {BLK, BLK, BLK, BLK}, 4'hF, 1'b1, -1, '0, -1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display bank. It is the parametrised successor to the single-nibble hex decoder.
- Holds an N-nibble display value in a shadow register and scans one digit per refresh slot. Drives shared active-low segment lines, a decimal point and per-digit anode enables.
- Sits between datapath/status logic and the board display pins, and is the only consumer of the raw display bus.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 1..16.
- REFRESH_DIV, 50000, clk cycles per digit slot; minimum 2.
- ANODE_ACTIVE_LOW, 1, 1 = anode enable drives 0, 0 = anode enable drives 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- value  in  4*NUM_DIGITS  hex nibbles; digit k = value[4k+3:4k]; digit 0 is rightmost.
- load  in  1  single-cycle strobe that captures value, dp_in and digit_en into the pending register.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 forces that digit dark.
- blank_lz  in  1  1 = suppress leading zeros.
- anode  out  NUM_DIGITS  one-hot digit select, polarity per ANODE_ACTIVE_LOW.
- seg  out  7  {a,b,c,d,e,f,g}, active low.
- dp_n  out  1  decimal point, active low.
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (async assert, sync release):
  - slot counter = 0, digit index = 0.
  - pending and active registers = 0, all digit_en bits = 0.
  - anode = all inactive, seg = 7'b1111111, dp_n = 1, frame_start = 0.
- Slot counter:
  - Counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and the digit index increments.
  - The digit index wraps from NUM_DIGITS-1 to 0.
- frame_start:
  - Asserted for exactly one cycle on the cycle the digit index becomes 0, including the first slot after reset release.
- Capture and tear-free update:
  - load captures into the pending register on the same edge.
  - A later load overwrites pending.
  - On frame_start, pending copies to active if a load occurred since the last frame; otherwise active holds.
  - If load and frame_start coincide, the new value is captured into pending. It reaches active at the next frame, never mid-frame.
- Dead time:
  - During slot count 0 of every digit, all anodes are inactive and seg is all-1, to prevent ghosting.
  - From count 1 onward, the selected anode is active and seg/dp_n reflect that digit.
- Outputs are registered: seg, dp_n and anode change on the same edge as each other.
- Segment encoding (a..g, active low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blanking, evaluated on the active register:
  - A digit is dark (seg all-1, dp_n=1, anode still driven) if its digit_en bit = 0.
  - Or if blank_lz = 1, its nibble = 0, and every higher-index digit is also zero or disabled.
  - Digit 0 is never leading-zero blanked.
  - dp_n of a digit that is lit = ~dp bit of that digit.
- Reset mid-scan: everything returns immediately to reset values. The scan restarts at digit 0, and the pending load is discarded.
- NUM_DIGITS = 1:
  - The digit index stays at 0.
  - frame_start pulses once per slot.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry segment pattern constant, SEG_BLANK = 7'b1111111;
  - a digit-index width function, clog2 of NUM_DIGITS with a minimum of 1.
- One sub-module, seg7_decode: a combinational nibble-to-segment decoder with a blank input, instantiated once on the muxed nibble.
- Scan counter, capture registers and leading-zero logic live in the top module.

Test Plan:
Sim configuration: NUM_DIGITS=4, REFRESH_DIV=4, ANODE_ACTIVE_LOW=1 unless noted.
1. Reset: hold reset_n=0 -> anode=4'b1111, seg=7'b1111111, dp_n=1; after release, frame_start pulses on the first cycle.
2. load value=16'h12AF, digit_en=4'hF, dp_in=4'b0100 -> from the next frame_start, the digit order 0..3 shows:
   - seg F=0111000, A=0001000 with dp_n=1, 2=0010010 with dp_n=0, 1=1001111;
   - anode sequence 1110, 1101, 1011, 0111;
   - slot count 0 of each digit is dark.
3. blank_lz=1, value=16'h0070 -> digits 3 and 2 are dark, digit 1 = 0001111, digit 0 = 0000001; value=16'h0000 -> only digit 0 is lit, showing 0000001.
4. Tear check: issue load 16'h1111 mid-frame, then 16'h2222 before frame end -> the current frame is unchanged; the next frame shows all digits 0010010; 16'h1111 never appears.
5. load coincident with frame_start -> the old value persists for that frame; the new value appears on the following frame_start.
6. Assert reset_n=0 while digit 2 is active and a load is pending -> immediate reset outputs; after release, active = 0 and scanning starts at digit 0; rerun with ANODE_ACTIVE_LOW=0 -> anode is one-hot high (0001, 0010, ...).
